// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin read arbiter draining bursts from NUM_CH FWFT FIFOs (optional macro FIFO_ARB_PRIO_EN)
module fifo_rd_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        ch_empty,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    output logic [NUM_CH-1:0]        ch_inc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last,
    output logic                     busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_last_q, rr_last_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;

    logic [DATA_W-1:0] rdata_arr [NUM_CH];
    logic              any_req;
    logic [CH_W-1:0]   rr_pick;
    logic              sel_empty;
    logic [CH_W-1:0]   rr_exit;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign rdata_arr[gi] = ch_rdata[gi*DATA_W +: DATA_W];
    end

    assign sel_empty = ch_empty[grant_q];
    assign any_req   = ~&ch_empty;

`ifdef FIFO_ARB_PRIO_EN
    // channel-0 grants leave the round-robin pointer where it was
    assign rr_exit = (grant_q != '0) ? grant_q : rr_last_q;
`else
    assign rr_exit = grant_q;
`endif

    // search downward so the last hit is the nearest channel after rr_last
    always_comb begin
        int              c;
        logic [CH_W-1:0] c_idx;
        rr_pick = '0;
        c       = 0;
        c_idx   = '0;
        for (int d = NUM_CH; d >= 1; d--) begin
            c     = (int'(rr_last_q) + d) % NUM_CH;
            c_idx = CH_W'(c);
`ifdef FIFO_ARB_PRIO_EN
            if (c_idx != '0 && !ch_empty[c_idx]) begin
                rr_pick = c_idx;
            end
`else
            if (!ch_empty[c_idx]) begin
                rr_pick = c_idx;
            end
`endif
        end
`ifdef FIFO_ARB_PRIO_EN
        if (!ch_empty[0]) begin
            rr_pick = '0;
        end
`endif
    end

    // next-state, pop strobe and handshake; clear overrides everything
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_last_d   = rr_last_q;
        burst_cnt_d = burst_cnt_q;
        out_valid   = 1'b0;
        ch_inc      = '0;
        if (clear) begin
            state_d     = IDLE;
            grant_d     = '0;
            rr_last_d   = CH_LAST;
            burst_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_d     = rr_pick;
                        burst_cnt_d = '0;
                        state_d     = BURST;
                    end
                end
                BURST: begin
                    out_valid = !sel_empty;
                    if (sel_empty) begin
                        state_d   = IDLE;
                        rr_last_d = rr_exit;
                    end else if (out_ready) begin
                        ch_inc[grant_q] = 1'b1;
                        if (burst_cnt_q == CNT_LAST) begin
                            state_d   = IDLE;
                            rr_last_d = rr_exit;
                        end else begin
                            burst_cnt_d = burst_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_last_q   <= CH_LAST;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_last_q   <= rr_last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign out_data = out_valid ? rdata_arr[grant_q] : '0;
    assign out_ch   = grant_q;
    assign out_last = out_valid && (burst_cnt_q == CNT_LAST);
    assign busy     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb/tb_fifo_rd_arbiter.sv - scoreboard bench for fifo_rd_arbiter with queue-based FIFO and arbitration model
module tb_fifo_rd_arbiter;

    localparam int NUM_CH    = 4;
    localparam int CH_W      = 2;
    localparam int DATA_W    = 32;
    localparam int BURST_MAX = 8;
    localparam int CNT_W     = 3;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     clear = 1'b0;
    logic [NUM_CH-1:0]        ch_empty = '1;
    logic [NUM_CH*DATA_W-1:0] ch_rdata = '0;
    logic [NUM_CH-1:0]        ch_inc;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_last;
    logic                     busy;

    fifo_rd_arbiter #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W),
        .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .ch_empty(ch_empty),
        .ch_rdata(ch_rdata), .ch_inc(ch_inc), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              valid;
        logic              busy;
        logic              last;
        logic [NUM_CH-1:0] inc;
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] fifo [NUM_CH][$];
    logic [NUM_CH-1:0] pop_mask = '0;
    int                total = 0;
    int                bad = 0;

    // reference model: "which channel owns the port and how many words it has given"
    bit m_burst = 0;
    int m_g     = 0;
    int m_rr    = NUM_CH - 1;
    int m_taken = 0;

    function automatic int pick();
        int r;
        r = -1;
`ifdef FIFO_ARB_PRIO_EN
        if (fifo[0].size() > 0) return 0;
`endif
        for (int d = 1; d <= NUM_CH; d++) begin
            int c;
            c = (m_rr + d) % NUM_CH;
`ifdef FIFO_ARB_PRIO_EN
            if (c == 0) continue;
`endif
            if (r < 0 && fifo[c].size() > 0) r = c;
        end
        return r;
    endfunction

    function automatic void finish_burst();
        m_burst = 0;
`ifdef FIFO_ARB_PRIO_EN
        if (m_g != 0) m_rr = m_g;
`else
        m_rr = m_g;
`endif
    endfunction

    function automatic void model_reset();
        m_burst = 0;
        m_rr    = NUM_CH - 1;
        m_taken = 0;
        m_g     = 0;
    endfunction

    task automatic drive_fifos();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_empty[i] = (fifo[i].size() == 0);
            ch_rdata[i*DATA_W +: DATA_W] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic cycle(input logic rdy, input logic clr, input int arrive);
        exp_t e;
        bit   pop;
        int   nxt;
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++)
            if (pop_mask[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        for (int i = 0; i < NUM_CH; i++)
            if ($urandom_range(99) < arrive && fifo[i].size() < 12) fifo[i].push_back($urandom);
        drive_fifos();
        out_ready = rdy;
        clear     = clr;
        #1;
        pop_mask = ch_inc;
        e.busy  = m_burst;
        e.valid = m_burst && !clr && fifo[m_g].size() > 0;
        pop     = e.valid && rdy;
        e.inc   = pop ? NUM_CH'(1 << m_g) : '0;
        e.ch    = CH_W'(m_g);
        e.data  = e.valid ? fifo[m_g][0] : '0;
        e.last  = e.valid && (m_taken == BURST_MAX - 1);
        exp_q.push_back(e);
        if (clr) begin
            model_reset();
        end else if (!m_burst) begin
            nxt = pick();
            if (nxt >= 0) begin
                m_g = nxt; m_burst = 1; m_taken = 0;
            end
        end else if (fifo[m_g].size() == 0) begin
            finish_burst();
        end else if (pop) begin
            m_taken++;
            if (m_taken == BURST_MAX) finish_burst();
        end
    endtask

    // monitor: one expected record per driven cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (out_valid !== e.valid || busy !== e.busy || ch_inc !== e.inc) begin
                    bad++;
                    $display("FAIL ctrl t=%0t got valid=%b busy=%b inc=%b want valid=%b busy=%b inc=%b",
                             $time, out_valid, busy, ch_inc, e.valid, e.busy, e.inc);
                end
                if (e.valid) begin
                    total++;
                    if (out_ch !== e.ch || out_data !== e.data || out_last !== e.last) begin
                        bad++;
                        $display("FAIL word t=%0t got ch=%0d data=%h last=%b want ch=%0d data=%h last=%b",
                                 $time, out_ch, out_data, out_last, e.ch, e.data, e.last);
                    end
                end else if (out_last !== 1'b0) begin
                    total++;
                    bad++;
                    $display("FAIL last_idle t=%0t got out_last=%b want 0", $time, out_last);
                end
            end
        end
    end

    task automatic check_quiet(input string name);
        total++;
        if (ch_inc !== '0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_last !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL %s got inc=%b valid=%b busy=%b last=%b data=%h want all 0",
                     name, ch_inc, out_valid, busy, out_last, out_data);
        end
    endtask

    initial begin
        // outputs stay quiet in reset even with every channel requesting
        for (int i = 0; i < NUM_CH; i++) fifo[i].push_back($urandom);
        drive_fifos();
        repeat (3) @(posedge clk);
        #1 check_quiet("reset_quiet");
        for (int i = 0; i < NUM_CH; i++) fifo[i].delete();
        drive_fifos();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single short channel: one idle cycle, three pops, early exit
        for (int k = 0; k < 3; k++) fifo[2].push_back(32'hC200_0000 + k);
        repeat (8) cycle(1'b1, 1'b0, 0);

        // clear then full load: bursts of BURST_MAX in order 0,1,2,3,0
        cycle(1'b1, 1'b1, 0);
        for (int i = 0; i < NUM_CH; i++)
            for (int k = 0; k < 20; k++) fifo[i].push_back({8'(i), 24'(k)});
        repeat (50) cycle(1'b1, 1'b0, 0);

        // stalls on a granted channel
        repeat (12) cycle(($urandom_range(1) == 1), 1'b0, 0);

        // clear mid-burst
        repeat (3) cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 0);
        repeat (12) cycle(1'b1, 1'b0, 0);

        // random traffic with sporadic clears and one asynchronous reset
        for (int n = 0; n < 1500; n++) begin
            cycle(($urandom_range(3) != 0), ($urandom_range(99) == 0), 15);
            if (n == 700) begin
                #2 rst_n = 1'b0;
                #1 check_quiet("async_reset");
                pop_mask = '0;
                model_reset();
                @(posedge clk);
                @(posedge clk);
                #1 check_quiet("reset_hold");
                rst_n = 1'b1;
            end
        end

        repeat (2) cycle(1'b0, 1'b0, 0);
        @(negedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
